uart_hex_tx: RTL and testbench
==============================

UART_HEX_TX -- requirements
Module: uart_hex_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_vld  input  1  request to send tx_word.
REQ-005 SHALL have port tx_word  input  16  word to print as hex.
REQ-006 SHALL have port tx_rdy  output  1  high when a request is accepted this cycle.
REQ-007 SHALL have port tx_done  output  1  one-cycle pulse after the final stop bit.
REQ-008 SHALL have port tx  output  1  UART serial line, idle high, registered.

Function
REQ-009 SHALL accept a request on a rising edge where tx_vld=1 and tx_rdy=1, latching tx_word; tx_rdy SHALL be low from the next cycle.
REQ-010 SHALL ignore tx_vld while tx_rdy=0; the latched word SHALL NOT change mid-message.
REQ-011 SHALL send the message: tx_word[15:12], [11:8], [7:4], [3:0] as ASCII hex, then terminator 0x0A.
REQ-012 SHALL encode nibbles 0-9 as 0x30-0x39 and A-F as lowercase 0x61-0x66.
REQ-013 SHALL frame each character as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-014 SHALL drive the start bit of character 0 on tx from the cycle after acceptance (one-cycle latency).
REQ-015 SHALL send characters back-to-back: the next start bit immediately follows the previous stop bit, no idle gap.
REQ-016 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on accept; START->DATA after CLKS_PER_BIT; DATA->STOP after 8th bit; STOP->START if characters remain, else STOP->IDLE.
REQ-017 SHALL use a bit-timer counting 0..CLKS_PER_BIT-1 that wraps to 0 at each bit boundary, a 3-bit data-bit index, and a character index 0..N-1.
REQ-018 SHALL pulse tx_done for exactly one cycle on the STOP->IDLE transition and set tx_rdy=1 in that same cycle.
REQ-019 SHALL allow a request in the cycle tx_rdy returns high; back-to-back messages have no idle bit between them.
REQ-020 SHALL keep total message duration N*10*CLKS_PER_BIT cycles, N = 5 (6 with CRLF).

Reset
REQ-021 SHALL, on rst=0, asynchronously force tx=1, tx_rdy=1, tx_done=0, state IDLE, all counters and the latched word to 0.
REQ-022 SHALL abort any frame in progress on reset; the line returns high immediately and no partial character resumes after release.
REQ-023 SHALL accept a request on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, with macro UART_HEX_TX_CRLF_EN defined, terminate each message with 0x0D then 0x0A (N=6).
REQ-025 SHALL, without UART_HEX_TX_CRLF_EN, terminate with 0x0A only (N=5); no 0x0D logic is present.

Structure
REQ-026 SHALL take from shared package uart_pkg: the state enum, ASCII constants (ASCII_LF 0x0A, ASCII_CR 0x0D, ASCII_0 0x30, ASCII_A_LC 0x61), and UART_DATA_BITS=8.
REQ-027 SHALL implement nibble-to-ASCII conversion as combinational sub-module nibble_to_ascii (4-bit in, 8-bit out), the inverse of the receive-side hex decode.
REQ-028 SHALL keep the bit-timer, FSM and shift register in uart_hex_tx; no FIFO.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 SHALL check: tx_word=16'h3A0F, one tx_vld pulse -> line decodes to "3a0f\n" (0x33,0x61,0x30,0x66,0x0A), each bit 4 cycles, tx_done pulses once at cycle 201.
REQ-030 SHALL check: tx_vld held high with 16'h0001 then 16'hFFFF -> "0001\n" immediately followed by "ffff\n", no idle bit between; second word accepted in the tx_done cycle.
REQ-031 SHALL check: tx_word changed to 16'h1234 and tx_vld pulsed mid-message -> ignored; output still matches the first word.
REQ-032 SHALL check: rst=0 asserted during DATA of character 2 -> tx=1 asynchronously, tx_rdy=1; after release, 16'hBEEF -> clean "beef\n".
REQ-033 SHALL check: UART_HEX_TX_CRLF_EN defined, 16'h00A5 -> "00a5\r\n", tx_done at 6*10*4+1=241 cycles after acceptance.
REQ-034 SHALL check: loopback into the team UART receiver at CLKS_PER_BIT=868 -> receiver rx_data equals each transmitted byte, rx_vld once per character.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, ASCII constants, frame width
// and the per-message character count.
// Build option: UART_HEX_TX_CRLF_EN selects a CR+LF terminator (6 chars) over LF only (5 chars).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;

  localparam int UART_DATA_BITS = 8;

  // Four hex digits plus the line terminator.
`ifdef UART_HEX_TX_CRLF_EN
  localparam int MSG_LEN = 6;
`else
  localparam int MSG_LEN = 5;
`endif

endpackage

// File: rtl/uart_hex_tx_if.sv
// Request/serial bundle for the hex-printing UART transmitter.
// Signals: tx_vld/tx_word (request), tx_rdy (accept), tx_done (end pulse), tx (serial line).
// slave = transmitter side, master = requester / line observer side.
interface uart_hex_tx_if;
  logic        tx_vld;
  logic [15:0] tx_word;
  logic        tx_rdy;
  logic        tx_done;
  logic        tx;

  modport slave (
    input  tx_vld,
    input  tx_word,
    output tx_rdy,
    output tx_done,
    output tx
  );

  modport master (
    output tx_vld,
    output tx_word,
    input  tx_rdy,
    input  tx_done,
    input  tx
  );
endinterface

// File: rtl/nibble_to_ascii.sv
// Purpose: map a 4-bit nibble to its lowercase ASCII hex digit (inverse of the receive-side decode).
// Latency: purely combinational.
// Backpressure: none.
// Ports: nib_i (4-bit nibble), ascii_o (8-bit character).
module nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = ASCII_0 + {4'd0, nib_i};
    if (nib_i > 4'd9) begin
      ascii_o = ASCII_A_LC + {4'd0, nib_i} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Purpose: print a 16-bit word on a UART line as four lowercase hex digits plus a line terminator.
// Latency: start bit of the first character on tx the cycle after acceptance; tx_done one cycle after the last stop bit.
// Backpressure: tx_rdy is high only in IDLE; requests while busy are ignored.
// Ports: clk, rst (async active-low), bus (slave: tx_vld, tx_word, tx_rdy, tx_done, tx).
// Build option: UART_HEX_TX_CRLF_EN appends CR before LF.
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst,
  uart_hex_tx_if.slave  bus
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  DBIT_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]  CHAR_LAST = 3'(MSG_LEN - 1);

  uart_state_e state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  char_idx_q, char_idx_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;

  logic        bit_end;
  logic [2:0]  load_idx;
  logic [15:0] load_word;
  logic [3:0]  load_nib;
  logic [7:0]  hex_char;
  logic [7:0]  load_char;

  assign bit_end = (timer_q == BIT_LAST);

  // Character to be loaded next: char 0 comes straight from the request word
  // so the start bit can go out the cycle after acceptance.
  always_comb begin
    load_idx  = 3'd0;
    load_word = word_q;
    if (state_q == IDLE) begin
      load_word = bus.tx_word;
    end else begin
      load_idx = char_idx_q + 3'd1;
    end
  end

  always_comb begin
    load_nib = 4'd0;
    case (load_idx)
      3'd0:    load_nib = load_word[15:12];
      3'd1:    load_nib = load_word[11:8];
      3'd2:    load_nib = load_word[7:4];
      3'd3:    load_nib = load_word[3:0];
      default: load_nib = 4'd0;
    endcase
  end

  nibble_to_ascii u_n2a (
    .nib_i   (load_nib),
    .ascii_o (hex_char)
  );

  always_comb begin
    load_char = ASCII_LF;
    if (load_idx < 3'd4) begin
      load_char = hex_char;
    end
`ifdef UART_HEX_TX_CRLF_EN
    else if (load_idx == 3'd4) begin
      load_char = ASCII_CR;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    word_d     = word_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_vld) begin
          word_d     = bus.tx_word;
          shift_d    = load_char;
          timer_d    = '0;
          bit_idx_d  = '0;
          char_idx_d = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        timer_d = timer_q + 16'd1;
        if (bit_end) begin
          timer_d = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        timer_d = timer_q + 16'd1;
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == DBIT_LAST) begin
            bit_idx_d = '0;
            tx_d      = 1'b1;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        timer_d = timer_q + 16'd1;
        if (bit_end) begin
          timer_d = '0;
          if (char_idx_q == CHAR_LAST) begin
            // Pulse lands in the first IDLE cycle, together with tx_rdy.
            done_d  = 1'b1;
            tx_d    = 1'b1;
            state_d = IDLE;
          end else begin
            char_idx_d = char_idx_q + 3'd1;
            shift_d    = load_char;
            tx_d       = 1'b0;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_done = done_q;
  assign bus.tx_rdy  = (state_q == IDLE);

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx at CLKS_PER_BIT=4: expected characters are queued when a word is
// requested and compared as a line monitor decodes each frame.
// Honours UART_HEX_TX_CRLF_EN for the expected terminator and message length.
module tb_uart_hex_tx;

  localparam int CPB = 4;
`ifdef UART_HEX_TX_CRLF_EN
  localparam int N_CHARS = 6;
`else
  localparam int N_CHARS = 5;
`endif
  localparam int FRAME    = 10 * CPB;
  localparam int DONE_IDX = N_CHARS * FRAME + 1;

  typedef struct {
    logic [7:0] ch;
    int         gap;  // expected cycles since previous start bit, 0 = don't care
  } exp_t;

  exp_t sb_q[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_hex_tx_if bus();

  uart_hex_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    return 8'h61 + {4'd0, n} - 8'd10;
  endfunction

  task automatic push_msg(input logic [15:0] w, input int first_gap);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      n = w[15 - 4*i -: 4];
      sb_q.push_back('{ch: hex_char(n), gap: (i == 0) ? first_gap : FRAME});
    end
`ifdef UART_HEX_TX_CRLF_EN
    sb_q.push_back('{ch: 8'h0D, gap: FRAME});
`endif
    sb_q.push_back('{ch: 8'h0A, gap: FRAME});
  endtask

  // Called at a negedge; the request is taken on the following rising edge.
  task automatic accept(input logic [15:0] w, input bit hold);
    check_eq("rdy_idle", bus.tx_rdy, 1);
    bus.tx_vld  = 1'b1;
    bus.tx_word = w;
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) bus.tx_vld = 1'b0;
    check_eq("rdy_busy", bus.tx_rdy, 0);
    check_eq("start_latency", bus.tx, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int at;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_done === 1'b1) begin
        at = cyc - acc_cyc + 1;
        break;
      end
    end
    check_eq(tag, at, DONE_IDX);
    if (at >= 0) check_eq({tag, "_rdy"}, bus.tx_rdy, 1);
  endtask

  // Line monitor: captures 40 samples per frame (one per cycle) starting at the
  // first low sample, and aborts the frame if reset is seen.
  initial begin : line_monitor
    logic [39:0] s;
    logic [7:0]  b;
    int          start_cyc;
    int          prev_start;
    int          bad;
    bit          ok;
    exp_t        e;
    prev_start = -1000;
    forever begin
      @(negedge clk);
      if (rst && bus.tx === 1'b0) begin
        start_cyc = cyc;
        s = '0;
        s[0] = bus.tx;
        ok = 1'b1;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (!rst) begin
            ok = 1'b0;
            break;
          end
          s[k] = bus.tx;
        end
        if (ok) begin
          bad = 0;
          for (int j = 0; j < 10; j++)
            for (int m = 0; m < 4; m++)
              if (s[4*j + m] !== s[4*j + 2]) bad++;
          for (int j = 0; j < 8; j++) b[j] = s[4*(j + 1) + 2];
          check_eq("bit_width", bad, 0);
          check_eq("frame_start_stop", {30'd0, s[2], s[38]}, 32'd1);
          if (sb_q.size() == 0) begin
            check_eq("sb_extra_char", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            check_eq("char", {24'd0, b}, {24'd0, e.ch});
            if (e.gap != 0) check_eq("char_gap", start_cyc - prev_start, e.gap);
          end
        end
        prev_start = start_cyc;
      end
    end
  end

  initial begin : stimulus
    logic [15:0] w;
    bus.tx_vld  = 1'b0;
    bus.tx_word = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_tx", bus.tx, 1);
    check_eq("rst_rdy", bus.tx_rdy, 1);
    check_eq("rst_done", bus.tx_done, 0);
    rst = 1'b1;

    // Single word, accepted on the first edge after reset; a mid-message request is ignored.
    push_msg(16'h3A0F, 0);
    accept(16'h3A0F, 1'b0);
    repeat (60) @(negedge clk);
    bus.tx_word = 16'h1234;
    bus.tx_vld  = 1'b1;
    @(negedge clk);
    bus.tx_vld  = 1'b0;
    wait_done("done_3a0f", 400);
    @(negedge clk);
    check_eq("done_width", bus.tx_done, 0);

    // tx_vld held high: second word is taken in the tx_done cycle.
    repeat (3) @(negedge clk);
    push_msg(16'h0001, 0);
    accept(16'h0001, 1'b1);
    bus.tx_word = 16'hFFFF;
    push_msg(16'hFFFF, FRAME + 1);
    wait_done("done_b2b_1", 400);
    @(negedge clk);
    acc_cyc = cyc;
    bus.tx_vld = 1'b0;
    check_eq("done_width_b2b", bus.tx_done, 0);
    check_eq("b2b_accepted", bus.tx_rdy, 0);
    wait_done("done_b2b_2", 400);
    @(negedge clk);
    check_eq("done_width_b2b2", bus.tx_done, 0);

    // A fixed and a random word.
    for (int i = 0; i < 2; i++) begin
      repeat (2) @(negedge clk);
      w = (i == 0) ? 16'h9ABC : 16'($urandom);
      push_msg(w, 0);
      accept(w, 1'b0);
      wait_done("done_word", 400);
    end

    // Reset during DATA of character 2, then a clean message.
    repeat (2) @(negedge clk);
    sb_q.push_back('{ch: hex_char(4'h5), gap: 0});
    sb_q.push_back('{ch: hex_char(4'h6), gap: FRAME});
    accept(16'h5678, 1'b0);
    repeat (93) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_tx", bus.tx, 1);
    check_eq("abort_rdy", bus.tx_rdy, 1);
    check_eq("abort_done", bus.tx_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_msg(16'hBEEF, 0);
    accept(16'hBEEF, 1'b0);
    wait_done("done_beef", 400);

    repeat (20) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
